alu_mult_seq: RTL
=================

# alu_mult_seq

Multi-cycle sequencer that computes an 8x8 unsigned multiply (16-bit product) by driving the shared 8-bit ALU in shift-add fashion. It owns the ALU's opcode, operand, carry-in and request-counter inputs while busy. It issues one unsigned add per multiplier bit and keeps the shifting of the accumulator and multiplier in its own registers. It sits between the core control path (start/busy/done handshake) and the ALU, which evaluates combinationally.

## Interface
- CTR_W, 12, width of the ALU request counter. Must equal the ALU's request-counter width.
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request a multiply; sampled only in IDLE
- a  in  8  multiplicand, captured on the accepted start
- b  in  8  multiplier, captured on the accepted start
- busy  out  1  high from the cycle after an accepted start through DONE
- done  out  1  one-cycle pulse in DONE; product is valid in that cycle
- product  out  16  result; holds its value until the next DONE
- alu_op  out  4  ALU opcode
- alu_a, alu_b  out  8  ALU operands
- alu_cin  out  1  ALU carry-in
- alu_ctr  out  CTR_W  ALU request counter
- alu_rslt  in  8  ALU result
- alu_cout  in  1  ALU carry-out

## Operation
- Internal registers:
  - mcand[7:0]
  - mplier[7:0]
  - acc_hi[7:0]
  - acc_c (1 bit)
  - cnt[2:0]
  - ctr[CTR_W-1:0]
- States and transitions:
  - IDLE: start=1 → capture mcand=a, mplier=b; clear acc_hi, acc_c, cnt; go to ADD.
  - ADD: drive alu_op=4'b1101 (unsigned add), alu_a=acc_hi, alu_b = mplier[0] ? mcand : 8'h00, alu_cin=0. At the clock edge capture {acc_c, acc_hi} = {alu_cout, alu_rslt}. Go to SHIFT.
  - SHIFT: {acc_c, acc_hi, mplier} shifts right by 1, MSB filled with 0; cnt++. If cnt==7, go to DONE; else go to ADD.
  - DONE: done=1; product={acc_hi, mplier} is registered on entry to DONE. Go to IDLE.
- Outside ADD: alu_op=4'b1111 (pass-through), alu_a=0, alu_b=0, alu_cin=0.
- ALU re-evaluates only when its request counter changes, so ctr increments on every entry into ADD. alu_ctr=ctr; wraps modulo 2^CTR_W.
- start while busy is ignored; no queueing.
- Arithmetic: the add is 8-bit plus carry-out. The carry is always absorbed by the following SHIFT. No overflow is possible in the 16-bit product.

## Timing
- Reset values (async assert, any state):
  - state=IDLE, busy=0, done=0, product=0
  - alu_op=4'b1111, alu_a=0, alu_b=0, alu_cin=0, alu_ctr=0
  - all internal registers 0
- Reset mid-operation aborts the multiply; no done pulse follows.
- Latency, with start accepted in cycle 0:
  - ADD/SHIFT pairs occupy cycles 1..16.
  - DONE and the done pulse fall in cycle 17.
  - A new start is accepted in cycle 18 at the earliest.
- ALU outputs are consumed in the same cycle they are driven (combinational ALU path). alu_* outputs are registered from state, so they are stable for the whole ADD cycle.
- busy=1 in cycles 1..17; done=1 in cycle 17 only.

## Configuration
- MULT_SKIP_ZERO_EN defined:
  - From IDLE and from SHIFT, the controller goes to ADD only if the next mplier[0]==1 (after the shift, when leaving SHIFT); otherwise it goes directly to SHIFT.
  - ctr increments only on ADD entries.
  - DONE lands in cycle 9+popcount(b).
- MULT_SKIP_ZERO_EN undefined: every bit takes ADD+SHIFT, giving a fixed 17-cycle latency to done.

## Test plan
- a=8'hFF, b=8'hFF, start in cycle 0 → done in cycle 17, product=16'hFE01. alu_ctr advanced by 8; carry path exercised.
- a=13, b=11 → product=16'd143. alu_op=4'b1101 only in ADD cycles, 4'b1111 otherwise.
- a=8'hA5, b=0 → product=0, done in cycle 17. With MULT_SKIP_ZERO_EN: done in cycle 9 and alu_ctr unchanged.
- start held high through a busy run with a/b changing mid-run → first result unaffected. The second op is accepted only in IDLE, at cycle 18.
- reset asserted in cycle 6 of a run → all outputs return to their reset values immediately and no done pulse follows. A fresh start then yields a correct product (e.g. 3*7=21).
- MULT_SKIP_ZERO_EN, a=8'h80, b=8'h01 → product=16'h0080, done in cycle 10.

Source files
------------

// File: rtl/alu_mult_seq.sv
// rtl/alu_mult_seq.sv - 8x8 shift-add multiply sequencer driving a shared combinational ALU
// Optional feature macro: MULT_SKIP_ZERO_EN (skip the ADD cycle for zero multiplier bits)
module alu_mult_seq #(
   parameter int CTR_W = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [7:0]       a,
   input  logic [7:0]       b,
   output logic             busy,
   output logic             done,
   output logic [15:0]      product,
   output logic [3:0]       alu_op,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic             alu_cin,
   output logic [CTR_W-1:0] alu_ctr,
   input  logic [7:0]       alu_rslt,
   input  logic             alu_cout
);

   localparam logic [3:0] OP_ADD  = 4'b1101;
   localparam logic [3:0] OP_PASS = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADD   = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state;
   logic [7:0]       mcand;
   logic [7:0]       mplier;
   logic [7:0]       acc_hi;
   logic             acc_c;
   logic [2:0]       cnt;
   logic [CTR_W-1:0] ctr;

   // Values of the accumulator and multiplier after a one-bit right shift of {acc_c, acc_hi, mplier}
   logic [7:0] acc_hi_sh;
   logic [7:0] mplier_sh;
   logic       add_from_idle;
   logic       add_from_shift;

   assign acc_hi_sh = {acc_c, acc_hi[7:1]};
   assign mplier_sh = {acc_hi[0], mplier[7:1]};

`ifdef MULT_SKIP_ZERO_EN
   assign add_from_idle  = b[0];
   assign add_from_shift = mplier_sh[0];
`else
   assign add_from_idle  = 1'b1;
   assign add_from_shift = 1'b1;
`endif

   assign alu_ctr = ctr;

   // Sequencer: state, datapath registers and registered ALU/handshake outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         mcand   <= 8'h00;
         mplier  <= 8'h00;
         acc_hi  <= 8'h00;
         acc_c   <= 1'b0;
         cnt     <= 3'd0;
         ctr     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= 16'h0000;
         alu_op  <= OP_PASS;
         alu_a   <= 8'h00;
         alu_b   <= 8'h00;
         alu_cin <= 1'b0;
      end else begin
         alu_op  <= OP_PASS;
         alu_a   <= 8'h00;
         alu_b   <= 8'h00;
         alu_cin <= 1'b0;
         done    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  mcand  <= a;
                  mplier <= b;
                  acc_hi <= 8'h00;
                  acc_c  <= 1'b0;
                  cnt    <= 3'd0;
                  busy   <= 1'b1;
                  if (add_from_idle) begin
                     state  <= S_ADD;
                     ctr    <= ctr + 1'b1;
                     alu_op <= OP_ADD;
                     alu_b  <= b[0] ? a : 8'h00;
                  end else begin
                     state <= S_SHIFT;
                  end
               end
            end
            S_ADD: begin
               acc_c  <= alu_cout;
               acc_hi <= alu_rslt;
               state  <= S_SHIFT;
            end
            S_SHIFT: begin
               acc_c  <= 1'b0;
               acc_hi <= acc_hi_sh;
               mplier <= mplier_sh;
               cnt    <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  state   <= S_DONE;
                  done    <= 1'b1;
                  product <= {acc_hi_sh, mplier_sh};
               end else if (add_from_shift) begin
                  state  <= S_ADD;
                  ctr    <= ctr + 1'b1;
                  alu_op <= OP_ADD;
                  alu_a  <= acc_hi_sh;
                  alu_b  <= mplier_sh[0] ? mcand : 8'h00;
               end else begin
                  state <= S_SHIFT;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
